// File: rtl/pipeline_pkg.sv
// Shared MEM-stage definitions: handshake states and MEM/WB bundle widths.
package pipeline_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CTRL_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } mem_state_e;

  // MEM/WB control bits; these are the fields zeroed by a bubble.
  typedef struct packed {
    logic halt;
    logic write_reg;
    logic wb;
    logic jalc;
    logic mem_err;
  } wb_ctrl_t;

endpackage

// File: rtl/dmem_handshake_fsm.sv
// Data-memory req/ack sequencer: issues one access, waits for ack or timeout,
// and parks the result while the WB side is frozen.
module dmem_handshake_fsm
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W  = pipeline_pkg::DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              access_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  input  logic              dmem_ack_i,
  output logic              idle_o,
  output logic              bubble_o,
  output logic              commit_o,
  output logic              err_o,
  output logic [DATA_W-1:0] data_o,
  output logic              mem_stall_o
);

  mem_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d;
  logic              cap_err_q, cap_err_d;
  logic              mem_stall_c;
  logic              done;
  logic              timeout_hit;
  logic [DATA_W-1:0] rdata_eff;

  // A timeout behaves like an ack that returns zero data and flags an error.
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1)) && !dmem_ack_i;
  assign done        = (state_q == WAIT) && (dmem_ack_i || timeout_hit);
  assign rdata_eff   = dmem_ack_i ? dmem_rdata_i : '0;

  // Next-state, request launch, result capture and stall generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cap_data_d  = cap_data_q;
    cap_err_d   = cap_err_q;
    bubble_o    = 1'b0;
    commit_o    = 1'b0;
    err_o       = 1'b0;
    data_o      = '0;
    mem_stall_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        mem_stall_c = access_i;
        if (access_i && !stall_i) begin
          bubble_o = 1'b1;
          req_d    = 1'b1;
          we_d     = we_i;
          addr_d   = addr_i;
          wdata_d  = wdata_i;
          cnt_d    = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        mem_stall_c = !(done && !stall_i);
        if (done) begin
          req_d      = 1'b0;
          cap_data_d = rdata_eff;
          cap_err_d  = !dmem_ack_i;
          if (!stall_i) begin
            commit_o = 1'b1;
            data_o   = rdata_eff;
            err_o    = !dmem_ack_i;
            state_d  = IDLE;
          end else begin
            state_d = HOLD;
          end
        end else begin
          bubble_o = 1'b1;
          cnt_d    = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        // Released in the same cycle stall drops so upstream advances with the commit.
        mem_stall_c = stall_i;
        data_o      = cap_data_q;
        err_o       = cap_err_q;
        if (!stall_i) begin
          commit_o = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake registers; reset drops the request immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cap_data_q <= '0;
      cap_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cap_data_q <= cap_data_d;
      cap_err_q  <= cap_err_d;
    end
  end

  assign idle_o       = (state_q == IDLE);
  assign mem_stall_o  = mem_stall_c && !reset;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;

endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM stage: runs the data-memory access and owns the MEM/WB pipeline register.
module mem_stage_access_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W  = pipeline_pkg::DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           M_Halt,
  input  logic                           M_WriteReg,
  input  logic                           M_WB,
  input  logic                           M_ReadMem,
  input  logic                           M_WriteMem,
  input  logic                           M_JALC,
  input  logic [DATA_W-1:0]              M_Num,
  input  logic [DATA_W-1:0]              M_RegData_2,
  input  logic [pipeline_pkg::REG_W-1:0] M_REG,
  input  logic [DATA_W-1:0]              M_PCREG,
  output logic                           dmem_req,
  output logic                           dmem_we,
  output logic [DATA_W-1:0]              dmem_addr,
  output logic [DATA_W-1:0]              dmem_wdata,
  input  logic [DATA_W-1:0]              dmem_rdata,
  input  logic                           dmem_ack,
  output logic                           mem_stall,
  output logic                           W_Halt,
  output logic                           W_WriteReg,
  output logic                           W_WB,
  output logic                           W_JALC,
  output logic                           W_MemErr,
  output logic [DATA_W-1:0]              W_Num,
  output logic [DATA_W-1:0]              W_MemData,
  output logic [DATA_W-1:0]              W_PCREG,
  output logic [pipeline_pkg::REG_W-1:0] W_REG
);

  wb_ctrl_t          w_ctrl_q, w_ctrl_d;
  logic [DATA_W-1:0] w_num_q, w_num_d;
  logic [DATA_W-1:0] w_md_q, w_md_d;
  logic [DATA_W-1:0] w_pc_q, w_pc_d;
  logic [REG_W-1:0]  w_reg_q, w_reg_d;
  logic              halted_q, halted_d;

  logic              access, misaligned, aligned;
  logic              fsm_idle, fsm_bubble, fsm_commit, fsm_err;
  logic [DATA_W-1:0] fsm_data;

  assign access     = (M_ReadMem || M_WriteMem) && !halted_q;
  assign misaligned = access && (M_Num[1:0] != 2'b00);
  assign aligned    = access && !misaligned;

  dmem_handshake_fsm #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clock        (clock),
    .reset        (reset),
    .stall_i      (stall),
    .access_i     (aligned),
    .we_i         (M_WriteMem),
    .addr_i       (M_Num),
    .wdata_i      (M_RegData_2),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata),
    .dmem_rdata_i (dmem_rdata),
    .dmem_ack_i   (dmem_ack),
    .idle_o       (fsm_idle),
    .bubble_o     (fsm_bubble),
    .commit_o     (fsm_commit),
    .err_o        (fsm_err),
    .data_o       (fsm_data),
    .mem_stall_o  (mem_stall)
  );

  // MEM/WB load, bubble or hold selection.
  always_comb begin
    w_ctrl_d = w_ctrl_q;
    w_num_d  = w_num_q;
    w_md_d   = w_md_q;
    w_pc_d   = w_pc_q;
    w_reg_d  = w_reg_q;
    if (fsm_commit) begin
      w_ctrl_d = {M_Halt, M_WriteReg && !fsm_err, M_WB, M_JALC, fsm_err};
      w_md_d   = fsm_data;
      w_num_d  = M_Num;
      w_pc_d   = M_PCREG;
      w_reg_d  = M_REG;
    end else if (fsm_bubble) begin
      w_ctrl_d = '0;
    end else if (fsm_idle && !aligned && !stall) begin
      if (misaligned) begin
        w_ctrl_d = {M_Halt, 1'b0, 1'b0, M_JALC, 1'b1};
      end else if (halted_q) begin
        w_ctrl_d = '0;
      end else begin
        w_ctrl_d = {M_Halt, M_WriteReg, M_WB, M_JALC, 1'b0};
      end
      w_md_d  = '0;
      w_num_d = M_Num;
      w_pc_d  = M_PCREG;
      w_reg_d = M_REG;
    end
    halted_d = halted_q || w_ctrl_d.halt;
  end

  // MEM/WB pipeline register and sticky halt flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_ctrl_q <= '0;
      w_num_q  <= '0;
      w_md_q   <= '0;
      w_pc_q   <= '0;
      w_reg_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      w_ctrl_q <= w_ctrl_d;
      w_num_q  <= w_num_d;
      w_md_q   <= w_md_d;
      w_pc_q   <= w_pc_d;
      w_reg_q  <= w_reg_d;
      halted_q <= halted_d;
    end
  end

  assign W_Halt     = w_ctrl_q.halt;
  assign W_WriteReg = w_ctrl_q.write_reg;
  assign W_WB       = w_ctrl_q.wb;
  assign W_JALC     = w_ctrl_q.jalc;
  assign W_MemErr   = w_ctrl_q.mem_err;
  assign W_Num      = w_num_q;
  assign W_MemData  = w_md_q;
  assign W_PCREG    = w_pc_q;
  assign W_REG      = w_reg_q;

endmodule
